execute_stage_m: RTL and testbench
==================================

Name: execute_stage_m

Overview:
Parametrised execute stage with operand forwarding, immediate select and an integrated multi-cycle RV32M multiply/divide engine. Base integer ops complete combinationally in one cycle through the team alu block, widened to XLEN. M-extension ops run in an internal FSM and stall the front of the pipeline until the result is ready. Sits between the ID/EX and EX/MEM pipeline registers; EX/MEM captures only when out_valid=1.

Parameters:
XLEN, 32, datapath width
REG_W, 5, register index width
ALU_OP_W, 4, base ALU opcode width
CTRL_W, 16, opaque control bundle width, passed through unchanged
MUL_CYCLES, 2, multiplier pipeline depth (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous kill of the current instruction
in_valid  in  1  ID/EX holds a valid instruction
pc  in  XLEN  instruction PC
ctrl_in  in  CTRL_W  control bundle
alu_op  in  ALU_OP_W  base ALU op
alu_src  in  1  1 = right operand is imm
is_m  in  1  M-extension op
m_funct3  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
data1, data2  in  XLEN  register-file operands
imm  in  XLEN  immediate
rs1, rs2, rd_in  in  REG_W  register indices
ex_mem_rd, mem_wb_rd  in  REG_W  downstream destination indices
ex_mem_regwrite, mem_wb_regwrite  in  1  downstream write enables
fwd_ex_mem, fwd_mem_wb  in  XLEN  forwarded values
stall  out  1  hold PC, IF/ID and ID/EX
out_valid  out  1  result valid this cycle
result  out  XLEN  ALU or M result
zero_flag  out  1  result == 0
store_data  out  XLEN  forwarded rs2
ctrl_out, rd_out, pc_out  out  CTRL_W/REG_W/XLEN  passthrough

Behaviour:
- Forwarding is evaluated per operand. EX/MEM is selected if ex_mem_regwrite && ex_mem_rd != 0 && ex_mem_rd == rs. Otherwise MEM/WB is selected if mem_wb_regwrite && mem_wb_rd != 0 && mem_wb_rd == rs. Otherwise the register-file value is used. EX/MEM wins when both match.
- Right operand = imm if alu_src, else forwarded rs2. store_data is always forwarded rs2.
- ctrl_out, rd_out and pc_out are combinational copies of their inputs. Upstream holds the inputs stable while stall=1.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE with in_valid && !is_m: result is the combinational ALU output; out_valid = in_valid; stall = 0.
- IDLE with in_valid && is_m && !flush: stall = 1 in the same cycle. Forwarded operands and m_funct3 are captured into registers, so later forwarding changes are ignored. Next state:
  - MUL for funct3 0-3.
  - DIV for funct3 4-7.
  - DONE directly for the special cases: divide by zero, or signed overflow (-2^(XLEN-1) / -1).
- MUL: 2*XLEN product computed with signedness per funct3 (MULHSU: rs1 signed, rs2 unsigned), delayed MUL_CYCLES. MUL returns the low XLEN bits; all other MUL ops return the high XLEN bits. After MUL_CYCLES cycles -> DONE.
- DIV: restoring radix-2 on magnitudes, one bit per cycle, XLEN cycles -> DONE. Quotient is negated if operand signs differ (signed ops). Remainder takes the sign of the dividend.
- Special-case results:
  - Divide by zero: quotient = all ones; remainder = dividend.
  - Signed overflow: quotient = dividend; remainder = 0.
- DONE: result comes from the result register; out_valid = 1; stall = 0. Next state is IDLE. The held instruction is not re-issued.
- stall = 1 in MUL and DIV, and in the IDLE accept cycle. Accept at cycle T:
  - Multiply: DONE at T+MUL_CYCLES+1.
  - Divide: DONE at T+XLEN+1.
  - Special case: DONE at T+1.
- zero_flag reflects whatever result is currently driven.
- flush: any state goes to IDLE on the next edge. In the flush cycle out_valid = 0, stall = 0, and no M op is started.
- Reset (asynchronous, any state, including mid-operation): state = IDLE; counter, capture registers and result register = 0. While rst_n = 0, stall = 0 and out_valid = 0 regardless of inputs.
- Back-to-back M ops: the second op is accepted in the IDLE cycle following DONE.

Test Plan:
- Forwarding: rs1 = 5 with ex_mem_rd = 5 (fwd 0x11) and mem_wb_rd = 5 (fwd 0x22), ADD with data2 = 1 -> result 0x12 in the same cycle. With rs1 = 0 and both downstream rd = 0 -> data1 is used.
- MUL 0xFFFFFFFF * 2 (MUL_CYCLES = 2): stall is high at T, T+1, T+2 -> at T+3 out_valid = 1, result 0xFFFFFFFE. MULHU of the same operands -> 0x00000001. MULH -> 0xFFFFFFFF.
- DIV -7 / 2 -> 0xFFFFFFFD, out_valid at T+33. REM -7 % 2 -> 0xFFFFFFFF. DIVU 100 / 7 -> 14, zero_flag = 0.
- DIV by 0 -> 0xFFFFFFFF at T+1. REMU 9 % 0 -> 9. DIV 0x80000000 / -1 -> 0x80000000. REM of the same -> 0 with zero_flag = 1.
- Capture: start DIV 20 / 3 with rs1 forwarded from EX/MEM, then change fwd_ex_mem every cycle -> result still 6.
- flush at T+5 of a DIV -> no out_valid, stall low, IDLE. rst_n pulsed low mid-MUL -> stall and out_valid are 0 immediately (asynchronously); a subsequent ADD completes normally.

Source files
------------

// File: rtl/execute_stage_m.sv
// Execute stage: operand forwarding, immediate select, base ALU and a
// multi-cycle RV32M multiply/divide engine that stalls the front end.
module execute_stage_m #(
    parameter int XLEN       = 32,
    parameter int REG_W      = 5,
    parameter int ALU_OP_W   = 4,
    parameter int CTRL_W     = 16,
    parameter int MUL_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    input  logic [XLEN-1:0]     pc,
    input  logic [CTRL_W-1:0]   ctrl_in,
    input  logic [ALU_OP_W-1:0] alu_op,
    input  logic                alu_src,
    input  logic                is_m,
    input  logic [2:0]          m_funct3,
    input  logic [XLEN-1:0]     data1,
    input  logic [XLEN-1:0]     data2,
    input  logic [XLEN-1:0]     imm,
    input  logic [REG_W-1:0]    rs1,
    input  logic [REG_W-1:0]    rs2,
    input  logic [REG_W-1:0]    rd_in,
    input  logic [REG_W-1:0]    ex_mem_rd,
    input  logic [REG_W-1:0]    mem_wb_rd,
    input  logic                ex_mem_regwrite,
    input  logic                mem_wb_regwrite,
    input  logic [XLEN-1:0]     fwd_ex_mem,
    input  logic [XLEN-1:0]     fwd_mem_wb,
    output logic                stall,
    output logic                out_valid,
    output logic [XLEN-1:0]     result,
    output logic                zero_flag,
    output logic [XLEN-1:0]     store_data,
    output logic [CTRL_W-1:0]   ctrl_out,
    output logic [REG_W-1:0]    rd_out,
    output logic [XLEN-1:0]     pc_out
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    localparam int CNT_W = $clog2(XLEN + MUL_CYCLES + 1);
    localparam int SH_W  = $clog2(XLEN);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   op_a, op_b, rem_q, res_q;
    logic [2:0]        f3_q;
    logic              neg_q, neg_r;

    logic              ex_a, wb_a, ex_b, wb_b;
    logic [XLEN-1:0]   fa, fb, rhs, alu_y;

    assign ex_a = ex_mem_regwrite && (ex_mem_rd != '0) && (ex_mem_rd == rs1);
    assign wb_a = mem_wb_regwrite && (mem_wb_rd != '0) && (mem_wb_rd == rs1);
    assign ex_b = ex_mem_regwrite && (ex_mem_rd != '0) && (ex_mem_rd == rs2);
    assign wb_b = mem_wb_regwrite && (mem_wb_rd != '0) && (mem_wb_rd == rs2);

    assign fa  = ex_a ? fwd_ex_mem : (wb_a ? fwd_mem_wb : data1);
    assign fb  = ex_b ? fwd_ex_mem : (wb_b ? fwd_mem_wb : data2);
    assign rhs = alu_src ? imm : fb;

    // 0 add 1 sub 2 sll 3 slt 4 sltu 5 xor 6 srl 7 sra 8 or 9 and, else pass rhs
    always_comb begin
        alu_y = rhs;
        case (alu_op)
            ALU_OP_W'(0): alu_y = fa + rhs;
            ALU_OP_W'(1): alu_y = fa - rhs;
            ALU_OP_W'(2): alu_y = fa << rhs[SH_W-1:0];
            ALU_OP_W'(3): alu_y = {{(XLEN-1){1'b0}}, $signed(fa) < $signed(rhs)};
            ALU_OP_W'(4): alu_y = {{(XLEN-1){1'b0}}, fa < rhs};
            ALU_OP_W'(5): alu_y = fa ^ rhs;
            ALU_OP_W'(6): alu_y = fa >> rhs[SH_W-1:0];
            ALU_OP_W'(7): alu_y = $signed(fa) >>> rhs[SH_W-1:0];
            ALU_OP_W'(8): alu_y = fa | rhs;
            ALU_OP_W'(9): alu_y = fa & rhs;
            default:      alu_y = rhs;
        endcase
    end

    logic              div_signed, a_neg, b_neg, div0, ovf, is_rem;
    logic [XLEN-1:0]   a_mag, b_mag, spec_res;

    assign div_signed = !m_funct3[0];
    assign is_rem     = m_funct3[1];
    assign a_neg      = div_signed && fa[XLEN-1];
    assign b_neg      = div_signed && fb[XLEN-1];
    assign a_mag      = a_neg ? -fa : fa;
    assign b_mag      = b_neg ? -fb : fb;
    assign div0       = (fb == '0);
    assign ovf        = div_signed && (fa == {1'b1, {(XLEN-1){1'b0}}}) && (fb == '1);
    assign spec_res   = div0 ? (is_rem ? fa : '1) : (is_rem ? '0 : fa);

    logic              mul_a_s, mul_b_s;
    logic [2*XLEN-1:0] pa, pb, prod;
    logic [XLEN-1:0]   mul_res;

    assign mul_a_s = (f3_q[1:0] == 2'd1) || (f3_q[1:0] == 2'd2);
    assign mul_b_s = (f3_q[1:0] == 2'd1);
    assign pa      = {{XLEN{mul_a_s & op_a[XLEN-1]}}, op_a};
    assign pb      = {{XLEN{mul_b_s & op_b[XLEN-1]}}, op_b};
    assign prod    = pa * pb;
    assign mul_res = (f3_q[1:0] == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    // op_a shifts the dividend out and the quotient in; op_b is the divisor
    logic [XLEN:0]     shifted;
    logic              ge;
    logic [XLEN-1:0]   rem_n, quo_n, div_res;

    assign shifted = {rem_q, op_a[XLEN-1]};
    assign ge      = shifted >= {1'b0, op_b};
    assign rem_n   = ge ? (shifted[XLEN-1:0] - op_b) : shifted[XLEN-1:0];
    assign quo_n   = {op_a[XLEN-2:0], ge};
    assign div_res = f3_q[1] ? (neg_r ? -rem_n : rem_n) : (neg_q ? -quo_n : quo_n);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            op_a  <= '0;
            op_b  <= '0;
            rem_q <= '0;
            res_q <= '0;
            f3_q  <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: if (in_valid && is_m) begin
                    f3_q  <= m_funct3;
                    cnt   <= '0;
                    rem_q <= '0;
                    neg_q <= a_neg ^ b_neg;
                    neg_r <= a_neg;
                    if (!m_funct3[2]) begin
                        op_a  <= fa;
                        op_b  <= fb;
                        state <= MUL;
                    end else if (div0 || ovf) begin
                        op_a  <= fa;
                        op_b  <= fb;
                        res_q <= spec_res;
                        state <= DONE;
                    end else begin
                        op_a  <= a_mag;
                        op_b  <= b_mag;
                        state <= DIV;
                    end
                end
                MUL: begin
                    if (cnt == CNT_W'(MUL_CYCLES - 1)) begin
                        res_q <= mul_res;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DIV: begin
                    op_a  <= quo_n;
                    rem_q <= rem_n;
                    if (cnt == CNT_W'(XLEN - 1)) begin
                        res_q <= div_res;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: state <= IDLE;
            endcase
        end
    end

    assign stall = rst_n && !flush &&
        (((state == IDLE) && in_valid && is_m) || (state == MUL) || (state == DIV));
    assign out_valid = rst_n && !flush &&
        (((state == IDLE) && in_valid && !is_m) || (state == DONE));

    assign result     = (state == DONE) ? res_q : alu_y;
    assign zero_flag  = (result == '0);
    assign store_data = fb;
    assign ctrl_out   = ctrl_in;
    assign rd_out     = rd_in;
    assign pc_out     = pc;
endmodule

// File: tb/tb_execute_stage_m.sv
// Bench for execute_stage_m: ALU/M vector table through a result
// scoreboard, plus forwarding, capture, flush and reset sequences.
module tb_execute_stage_m;
    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, alu_src, is_m;
    logic [31:0] pc, data1, data2, imm, fwd_ex_mem, fwd_mem_wb;
    logic [15:0] ctrl_in;
    logic [3:0]  alu_op;
    logic [2:0]  m_funct3;
    logic [4:0]  rs1, rs2, rd_in, ex_mem_rd, mem_wb_rd;
    logic        ex_mem_regwrite, mem_wb_regwrite;
    logic        stall, out_valid, zero_flag;
    logic [31:0] result, store_data, pc_out;
    logic [15:0] ctrl_out;
    logic [4:0]  rd_out;

    execute_stage_m dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .pc(pc), .ctrl_in(ctrl_in), .alu_op(alu_op), .alu_src(alu_src),
        .is_m(is_m), .m_funct3(m_funct3), .data1(data1), .data2(data2),
        .imm(imm), .rs1(rs1), .rs2(rs2), .rd_in(rd_in),
        .ex_mem_rd(ex_mem_rd), .mem_wb_rd(mem_wb_rd),
        .ex_mem_regwrite(ex_mem_regwrite), .mem_wb_regwrite(mem_wb_regwrite),
        .fwd_ex_mem(fwd_ex_mem), .fwd_mem_wb(fwd_mem_wb),
        .stall(stall), .out_valid(out_valid), .result(result),
        .zero_flag(zero_flag), .store_data(store_data),
        .ctrl_out(ctrl_out), .rd_out(rd_out), .pc_out(pc_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic        src;
        logic        m;
        logic [2:0]  f3;
        logic [31:0] a, b, imm, exp;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    vec_t tv[$];
    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    bit   wiggle = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic add(input logic [3:0] op, input logic src, input logic m,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic [31:0] ex, input int lat);
        vec_t v;
        v.op = op; v.src = src; v.m = m; v.f3 = f3;
        v.a = a; v.b = b; v.imm = im; v.exp = ex; v.lat = lat;
        tv.push_back(v);
    endtask

    // Inputs are already driven for cycle T; waits for out_valid and scores it.
    task automatic run(input string nm, input logic [31:0] exp, input int lat);
        exp_t e;
        int   seen;
        int   stall_miss;
        e.res = exp;
        e.lat = lat;
        sb.push_back(e);
        seen = -1;
        stall_miss = 0;
        for (int c = 0; c <= 60 && seen < 0; c++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = c;
                e = sb.pop_front();
                chk({nm, ".res"}, result, e.res);
                chk({nm, ".zero"}, 32'(zero_flag), 32'(e.res == 32'd0));
                chk({nm, ".lat"}, c, e.lat);
                chk({nm, ".stall_out"}, 32'(stall), 32'd0);
            end else if (!stall) begin
                stall_miss++;
            end
            if (wiggle && c > 0) fwd_ex_mem = $urandom;
        end
        if (seen < 0) begin
            total++;
            bad++;
            $display("FAIL %s.timeout actual=none required=out_valid", nm);
            sb.delete();
        end else begin
            chk({nm, ".stall"}, stall_miss, 0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic clear_fwd();
        rs1 = 0; rs2 = 0; ex_mem_rd = 0; mem_wb_rd = 0;
        ex_mem_regwrite = 0; mem_wb_regwrite = 0;
        fwd_ex_mem = 0; fwd_mem_wb = 0;
    endtask

    initial begin
        int hits;
        rst_n = 0; flush = 0; in_valid = 1; alu_src = 0; is_m = 0;
        pc = 32'h1000; ctrl_in = 16'hBEEF; alu_op = 0; m_funct3 = 0;
        data1 = 1; data2 = 2; imm = 0; rd_in = 5'd9;
        clear_fwd();

        #2;
        chk("rst.out_valid", 32'(out_valid), 0);
        chk("rst.stall", 32'(stall), 0);
        is_m = 1;
        #1;
        chk("rst.stall_m", 32'(stall), 0);
        in_valid = 0;
        is_m = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("idle.out_valid", 32'(out_valid), 0);
        chk("idle.stall", 32'(stall), 0);
        @(posedge clk);
        #1;

        // ALU: 0 add 1 sub 2 sll 3 slt 4 sltu 5 xor 6 srl 7 sra 8 or 9 and
        add(0, 0, 0, 0, 5, 7, 0, 12, 0);
        add(1, 0, 0, 0, 5, 7, 0, 32'hFFFFFFFE, 0);
        add(1, 0, 0, 0, 7, 7, 0, 0, 0);
        add(2, 1, 0, 0, 1, 99, 4, 32'h10, 0);
        add(3, 0, 0, 0, 32'hFFFFFFFF, 1, 0, 1, 0);
        add(4, 0, 0, 0, 32'hFFFFFFFF, 1, 0, 0, 0);
        add(5, 0, 0, 0, 32'hF0F0, 32'hFFFF, 0, 32'h0F0F, 0);
        add(6, 1, 0, 0, 32'h80000000, 0, 4, 32'h08000000, 0);
        add(7, 1, 0, 0, 32'h80000000, 0, 4, 32'hF8000000, 0);
        add(8, 0, 0, 0, 32'hF0, 32'h0F, 0, 32'hFF, 0);
        add(9, 0, 0, 0, 32'hF0, 32'h0F, 0, 0, 0);
        // M ops, back to back
        add(0, 0, 1, 0, 32'hFFFFFFFF, 2, 0, 32'hFFFFFFFE, 3);
        add(0, 0, 1, 3, 32'hFFFFFFFF, 2, 0, 32'h00000001, 3);
        add(0, 0, 1, 1, 32'hFFFFFFFF, 2, 0, 32'hFFFFFFFF, 3);
        add(0, 0, 1, 2, 2, 32'hFFFFFFFF, 0, 32'h00000001, 3);
        add(0, 0, 1, 4, 32'hFFFFFFF9, 2, 0, 32'hFFFFFFFD, 33);
        add(0, 0, 1, 6, 32'hFFFFFFF9, 2, 0, 32'hFFFFFFFF, 33);
        add(0, 0, 1, 5, 100, 7, 0, 14, 33);
        add(0, 0, 1, 7, 100, 7, 0, 2, 33);
        add(0, 0, 1, 4, 7, 32'hFFFFFFFE, 0, 32'hFFFFFFFD, 33);
        add(0, 0, 1, 6, 7, 32'hFFFFFFFE, 0, 1, 33);
        add(0, 0, 1, 5, 32'h80000000, 32'hFFFFFFFF, 0, 0, 33);
        add(0, 0, 1, 7, 32'h80000000, 32'hFFFFFFFF, 0, 32'h80000000, 33);
        add(0, 0, 1, 4, 1234, 0, 0, 32'hFFFFFFFF, 1);
        add(0, 0, 1, 7, 9, 0, 0, 9, 1);
        add(0, 0, 1, 4, 32'h80000000, 32'hFFFFFFFF, 0, 32'h80000000, 1);
        add(0, 0, 1, 6, 32'h80000000, 32'hFFFFFFFF, 0, 0, 1);

        foreach (tv[i]) begin
            alu_op = tv[i].op; alu_src = tv[i].src; is_m = tv[i].m;
            m_funct3 = tv[i].f3; data1 = tv[i].a; data2 = tv[i].b;
            imm = tv[i].imm; in_valid = 1;
            run($sformatf("vec%0d", i), tv[i].exp, tv[i].lat);
        end

        // forwarding priority
        is_m = 0; alu_op = 0; alu_src = 0;
        rs1 = 5; rs2 = 0; ex_mem_rd = 5; mem_wb_rd = 5;
        ex_mem_regwrite = 1; mem_wb_regwrite = 1;
        fwd_ex_mem = 32'h11; fwd_mem_wb = 32'h22; data1 = 32'h777; data2 = 1;
        in_valid = 1;
        run("fwd_ex", 32'h12, 0);
        ex_mem_rd = 6; in_valid = 1;
        run("fwd_wb", 32'h23, 0);
        rs1 = 0; ex_mem_rd = 0; mem_wb_rd = 0; data1 = 32'h100; in_valid = 1;
        run("fwd_x0", 32'h101, 0);
        rs2 = 7; mem_wb_rd = 7; fwd_mem_wb = 32'hABCD; alu_src = 1; imm = 3;
        data1 = 32'h10; data2 = 32'h55; in_valid = 1;
        #1;
        chk("store_fwd", store_data, 32'hABCD);
        chk("pc_out", pc_out, 32'h1000);
        chk("ctrl_out", 32'(ctrl_out), 32'hBEEF);
        chk("rd_out", 32'(rd_out), 9);
        run("fwd_imm", 32'h13, 0);

        // operand capture: rs1 forwarded, then forwarding value churns
        clear_fwd();
        rs1 = 5; ex_mem_rd = 5; ex_mem_regwrite = 1; fwd_ex_mem = 20;
        data1 = 999; data2 = 3; alu_src = 0; is_m = 1; m_funct3 = 4;
        in_valid = 1; wiggle = 1;
        run("capture", 6, 33);
        wiggle = 0;
        clear_fwd();

        // flush mid-divide
        data1 = 20; data2 = 3; is_m = 1; m_funct3 = 4; in_valid = 1;
        repeat (5) @(posedge clk);
        #1;
        flush = 1;
        @(negedge clk);
        chk("flush.stall", 32'(stall), 0);
        chk("flush.out_valid", 32'(out_valid), 0);
        @(posedge clk);
        #1;
        flush = 0; in_valid = 0;
        hits = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid || stall) hits++;
        end
        chk("flush.quiet", hits, 0);
        @(posedge clk);
        #1;
        is_m = 0; alu_op = 0; data1 = 40; data2 = 2; in_valid = 1;
        run("post_flush", 42, 0);

        // async reset in the middle of a multiply
        is_m = 1; m_funct3 = 0; data1 = 6; data2 = 7; in_valid = 1;
        @(posedge clk);
        #3;
        rst_n = 0;
        #1;
        chk("amid.stall", 32'(stall), 0);
        chk("amid.out_valid", 32'(out_valid), 0);
        in_valid = 0;
        @(negedge clk);
        rst_n = 1;
        hits = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_valid || stall) hits++;
        end
        chk("amid.quiet", hits, 0);
        @(posedge clk);
        #1;
        is_m = 0; alu_op = 0; data1 = 3; data2 = 4; in_valid = 1;
        run("post_reset", 7, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
